// File: rtl/bsg_chip_pkg.sv
// Shared chip-level types and defaults, including the SDR link bring-up
// sequencer state encoding used by both link sides.
package bsg_chip_pkg;

    localparam int sdr_token_reset_cycles_gp = 4;
    localparam int sdr_settle_cycles_gp      = 8;
    localparam int sdr_wait_cnt_width_gp     = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TOKEN_ON   = 3'd1,
        TOKEN_OFF  = 3'd2,
        UPLINK     = 3'd3,
        DOWNLINK   = 3'd4,
        DOWNSTREAM = 3'd5,
        UP         = 3'd6
    } sdr_link_seq_state_e;

    // States that dwell for a programmed number of cycles before moving on.
    function automatic logic is_timed_state(input sdr_link_seq_state_e s);
        return (s inside {TOKEN_ON, TOKEN_OFF, UPLINK, DOWNLINK, DOWNSTREAM});
    endfunction

endpackage

// File: rtl/bsg_sdr_link_reset_sequencer.sv
// Per-side SDR link bring-up controller: pulses the token reset, then releases
// uplink, downlink and downstream resets in order with settle gaps.
module bsg_sdr_link_reset_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int token_cycles_p      = sdr_token_reset_cycles_gp,
    parameter int settle_cycles_p     = sdr_settle_cycles_gp,
    parameter int restart_cnt_width_p = 8
) (
    input  logic                           core_clk_i,
    input  logic                           core_reset_n_i,
    input  logic                           en_i,
    input  logic                           restart_i,
    output logic                           core_uplink_reset_o,
    output logic                           core_downlink_reset_o,
    output logic                           core_downstream_reset_o,
    output logic                           async_token_reset_o,
    output logic                           link_up_o,
    output logic [2:0]                     state_o,
    output logic [restart_cnt_width_p-1:0] restart_count_o
);

    if (token_cycles_p < 1 || token_cycles_p > 255) begin : g_bad_token_cycles
        $error("token_cycles_p must be in 1..255");
    end
    if (settle_cycles_p < 1 || settle_cycles_p > 255) begin : g_bad_settle_cycles
        $error("settle_cycles_p must be in 1..255");
    end

    localparam logic [sdr_wait_cnt_width_gp-1:0] token_last_lp  =
        sdr_wait_cnt_width_gp'(token_cycles_p - 1);
    localparam logic [sdr_wait_cnt_width_gp-1:0] settle_last_lp =
        sdr_wait_cnt_width_gp'(settle_cycles_p - 1);

    sdr_link_seq_state_e               state_r, state_n;
    logic [sdr_wait_cnt_width_gp-1:0]  wait_cnt_r, wait_cnt_n;
    logic                              abort;
    logic                              restart_bump;
    logic                              uplink_reset_n, downlink_reset_n, downstream_reset_n;
    logic                              token_reset_n, link_up_n;

    // Abort outranks every timed exit; unused encodings fall back to IDLE.
    always_comb begin
        state_n = state_r;
        abort   = !en_i || restart_i;
        case (state_r)
            IDLE:       if (en_i && !restart_i)           state_n = TOKEN_ON;
            TOKEN_ON:   if (wait_cnt_r == token_last_lp)  state_n = TOKEN_OFF;
            TOKEN_OFF:  if (wait_cnt_r == settle_last_lp) state_n = UPLINK;
            UPLINK:     if (wait_cnt_r == settle_last_lp) state_n = DOWNLINK;
            DOWNLINK:   if (wait_cnt_r == settle_last_lp) state_n = DOWNSTREAM;
            DOWNSTREAM: if (wait_cnt_r == settle_last_lp) state_n = UP;
            UP:         state_n = UP;
            default:    state_n = IDLE;
        endcase
        if (abort && state_r != IDLE) state_n = IDLE;
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself and never depend combinationally on inputs.
    always_comb begin
        uplink_reset_n     = 1'b1;
        downlink_reset_n   = 1'b1;
        downstream_reset_n = 1'b1;
        token_reset_n      = 1'b0;
        link_up_n          = 1'b0;
        case (state_n)
            TOKEN_ON:   token_reset_n = 1'b1;
            UPLINK:     uplink_reset_n = 1'b0;
            DOWNLINK: begin
                uplink_reset_n   = 1'b0;
                downlink_reset_n = 1'b0;
            end
            DOWNSTREAM: begin
                uplink_reset_n     = 1'b0;
                downlink_reset_n   = 1'b0;
                downstream_reset_n = 1'b0;
            end
            UP: begin
                uplink_reset_n     = 1'b0;
                downlink_reset_n   = 1'b0;
                downstream_reset_n = 1'b0;
                link_up_n          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_r                 <= IDLE;
            core_uplink_reset_o     <= 1'b1;
            core_downlink_reset_o   <= 1'b1;
            core_downstream_reset_o <= 1'b1;
            async_token_reset_o     <= 1'b0;
            link_up_o               <= 1'b0;
        end else begin
            state_r                 <= state_n;
            core_uplink_reset_o     <= uplink_reset_n;
            core_downlink_reset_o   <= downlink_reset_n;
            core_downstream_reset_o <= downstream_reset_n;
            async_token_reset_o     <= token_reset_n;
            link_up_o               <= link_up_n;
        end
    end

    assign state_o = state_r;

    // Dwell counter restarts from zero whenever a new state is entered.
    always_comb begin
        wait_cnt_n = wait_cnt_r;
        if (state_n != state_r)
            wait_cnt_n = '0;
        else if (is_timed_state(state_r))
            wait_cnt_n = wait_cnt_r + 1'b1;
    end

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) wait_cnt_r <= '0;
        else                 wait_cnt_r <= wait_cnt_n;
    end

    // Only restart-driven teardowns of a live link are counted.
    assign restart_bump = (state_r == UP) && restart_i;

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i)
            restart_count_o <= '0;
        else if (restart_bump && (restart_count_o != '1))
            restart_count_o <= restart_count_o + restart_cnt_width_p'(1);
    end

endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// Bench for the SDR link reset sequencer: a timeline model predicts every
// output cycle by cycle for a default and a minimum-timing instance.
module tb_bsg_sdr_link_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en [2];
    logic       restart [2];
    logic       upl [2];
    logic       dnl [2];
    logic       dsr [2];
    logic       tok [2];
    logic       lu [2];
    logic [2:0] st [2];
    logic [7:0] rc [2];

    int compared   = 0;
    int mismatched = 0;
    int edge_num   = 0;

    int tCyc [2] = '{4, 1};
    int sCyc [2] = '{8, 1};

    bit m_active [2] = '{0, 0};
    int m_n [2]      = '{0, 0};
    int m_cnt [2]    = '{0, 0};

    always #5 clk = ~clk;

    bsg_sdr_link_reset_sequencer dut0 (
        .core_clk_i              (clk),
        .core_reset_n_i          (rst_n),
        .en_i                    (en[0]),
        .restart_i               (restart[0]),
        .core_uplink_reset_o     (upl[0]),
        .core_downlink_reset_o   (dnl[0]),
        .core_downstream_reset_o (dsr[0]),
        .async_token_reset_o     (tok[0]),
        .link_up_o               (lu[0]),
        .state_o                 (st[0]),
        .restart_count_o         (rc[0])
    );

    bsg_sdr_link_reset_sequencer #(
        .token_cycles_p      (1),
        .settle_cycles_p     (1),
        .restart_cnt_width_p (8)
    ) dut1 (
        .core_clk_i              (clk),
        .core_reset_n_i          (rst_n),
        .en_i                    (en[1]),
        .restart_i               (restart[1]),
        .core_uplink_reset_o     (upl[1]),
        .core_downlink_reset_o   (dnl[1]),
        .core_downstream_reset_o (dsr[1]),
        .async_token_reset_o     (tok[1]),
        .link_up_o               (lu[1]),
        .state_o                 (st[1]),
        .restart_count_o         (rc[1])
    );

    always @(posedge clk) edge_num <= edge_num + 1;

    // Model: m_n is the number of edges since the sequence started, saturating
    // once the link is up; every output is a threshold on that elapsed time.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_active[i] = 1'b0;
                m_n[i]      = 0;
                m_cnt[i]    = 0;
            end else if (m_active[i]) begin
                if (!en[i] || restart[i]) begin
                    if (restart[i] && m_n[i] >= tCyc[i] + 4 * sCyc[i] && m_cnt[i] < 255)
                        m_cnt[i] = m_cnt[i] + 1;
                    m_active[i] = 1'b0;
                end else if (m_n[i] < tCyc[i] + 4 * sCyc[i]) begin
                    m_n[i] = m_n[i] + 1;
                end
            end else if (en[i] && !restart[i]) begin
                m_active[i] = 1'b1;
                m_n[i]      = 0;
            end
        end
    end

    function automatic int heldBelow(input int i, input int lim);
        return (!m_active[i] || m_n[i] < lim) ? 1 : 0;
    endfunction

    function automatic int expState(input int i);
        if (!m_active[i])                       return 0;
        if (m_n[i] < tCyc[i])                   return 1;
        if (m_n[i] >= tCyc[i] + 4 * sCyc[i])    return 6;
        return 2 + (m_n[i] - tCyc[i]) / sCyc[i];
    endfunction

    task automatic checkOutput(input string name, input int idx, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s[dut%0d] @%0t: got %0d, expected %0d", name, idx, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput("uplink_reset", i, int'(upl[i]), heldBelow(i, tCyc[i] + sCyc[i]));
            checkOutput("downlink_reset", i, int'(dnl[i]), heldBelow(i, tCyc[i] + 2 * sCyc[i]));
            checkOutput("downstream_reset", i, int'(dsr[i]), heldBelow(i, tCyc[i] + 3 * sCyc[i]));
            checkOutput("token_reset", i, int'(tok[i]), (m_active[i] && m_n[i] < tCyc[i]) ? 1 : 0);
            checkOutput("link_up", i, int'(lu[i]), (m_active[i] && m_n[i] >= tCyc[i] + 4 * sCyc[i]) ? 1 : 0);
            checkOutput("state", i, int'(st[i]), expState(i));
            checkOutput("restart_count", i, int'(rc[i]), m_cnt[i]);
        end
    end

    task automatic applyStimulus(input int i, input logic e, input logic r);
        @(negedge clk);
        en[i]      = e;
        restart[i] = r;
    endtask

    task automatic waitState(input int i, input logic [2:0] s, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (st[i] == s) break;
        end
        checkOutput("wait_state", i, int'(st[i]), int'(s));
    endtask

    // Starts a sequence and records the edge offset of each output transition.
    task automatic measureBringUp(input int i, input int budget,
                                  output int tokFall, output int uplFall, output int dnlFall,
                                  output int dsFall, output int luRise);
        int k;
        int e;
        tokFall = -1; uplFall = -1; dnlFall = -1; dsFall = -1; luRise = -1;
        applyStimulus(i, 1'b1, 1'b0);
        k = edge_num + 1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            e = edge_num - k;
            if (!tok[i] && tokFall < 0) tokFall = e;
            if (!upl[i] && uplFall < 0) uplFall = e;
            if (!dnl[i] && dnlFall < 0) dnlFall = e;
            if (!dsr[i] && dsFall < 0)  dsFall  = e;
            if (lu[i]) begin
                luRise = e;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tf, uf, df, sf, lr, r, saved;
        en[0] = 1'b0; en[1] = 1'b0;
        restart[0] = 1'b0; restart[1] = 1'b0;
        rst_n = 1'b0;

        // Power-on reset, then idle with en low.
        repeat (3) @(negedge clk);
        checkOutput("por_state", 0, int'(st[0]), 0);
        checkOutput("por_uplink", 0, int'(upl[0]), 1);
        checkOutput("por_token", 0, int'(tok[0]), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_hold_state", 0, int'(st[0]), 0);
        checkOutput("idle_hold_link_up", 0, int'(lu[0]), 0);

        // Full bring-up timing with default parameters.
        measureBringUp(0, 60, tf, uf, df, sf, lr);
        $display("[TB] bring-up offsets: token off %0d, uplink %0d, downlink %0d, downstream %0d, up %0d",
                 tf, uf, df, sf, lr);
        checkOutput("token_fall_edge", 0, tf, 4);
        checkOutput("uplink_release_edge", 0, uf, 12);
        checkOutput("downlink_release_edge", 0, df, 20);
        checkOutput("downstream_release_edge", 0, sf, 28);
        checkOutput("link_up_edge", 0, lr, 36);

        // One-cycle restart pulse from UP.
        applyStimulus(0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        r = edge_num;
        checkOutput("restart_uplink", 0, int'(upl[0]), 1);
        checkOutput("restart_link_up", 0, int'(lu[0]), 0);
        checkOutput("restart_count_1", 0, int'(rc[0]), 1);
        lr = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (lu[0]) begin
                lr = edge_num - r;
                break;
            end
        end
        checkOutput("relink_latency", 0, lr, 37);

        // Drop en while in UPLINK; the count must not move.
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0);
        waitState(0, 3'd3, 40);
        saved = int'(rc[0]);
        applyStimulus(0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_state", 0, int'(st[0]), 0);
        checkOutput("abort_uplink", 0, int'(upl[0]), 1);
        checkOutput("abort_count", 0, int'(rc[0]), 1);
        checkOutput("abort_count_stable", 0, int'(rc[0]), saved);
        applyStimulus(0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("resequence_state", 0, int'(st[0]), 1);
        checkOutput("resequence_token", 0, int'(tok[0]), 1);

        // Asynchronous reset between edges while in DOWNLINK.
        waitState(0, 3'd4, 60);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_state", 0, int'(st[0]), 0);
        checkOutput("async_uplink", 0, int'(upl[0]), 1);
        checkOutput("async_downlink", 0, int'(dnl[0]), 1);
        checkOutput("async_downstream", 0, int'(dsr[0]), 1);
        checkOutput("async_token", 0, int'(tok[0]), 0);
        checkOutput("async_count", 0, int'(rc[0]), 0);
        en[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_state", 0, int'(st[0]), 0);

        // Minimum timing instance and restart counter saturation.
        measureBringUp(1, 20, tf, uf, df, sf, lr);
        checkOutput("fast_token_fall", 1, tf, 1);
        checkOutput("fast_link_up_edge", 1, lr, 5);
        for (int i = 0; i < 300; i++) begin
            for (int n = 0; n < 20; n++) begin
                if (lu[1]) break;
                @(negedge clk);
            end
            applyStimulus(1, 1'b1, 1'b1);
            applyStimulus(1, 1'b1, 1'b0);
            if (i == 0) checkOutput("fast_count_first", 1, int'(rc[1]), 1);
        end
        @(negedge clk);
        checkOutput("fast_count_saturated", 1, int'(rc[1]), 255);

        applyStimulus(1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
